// File: rtl/line_drawer_pkg.sv
// Shared constants and types for the Bresenham line drawer and its upstream plot logic.
package line_drawer_pkg;

  localparam int unsigned HOR_ACTIVE_PIXELS = 640;
  localparam int unsigned VER_ACTIVE_PIXELS = 480;
  localparam int unsigned X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS);
  localparam int unsigned Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS);
  localparam int unsigned ERR_WIDTH         = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
  } point_t;

endpackage

// File: rtl/line_drawer.sv
// Rasterises one segment per command with integer Bresenham, emitting one pixel per
// cycle under valid/ready backpressure; off-screen pixels are skipped without output.
module line_drawer
  import line_drawer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  input  logic               start,
  output logic               ready,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);

  state_e                        state_q, state_d;
  point_t                        cur_q, cur_d;
  point_t                        end_q, end_d;
  logic signed [ERR_WIDTH-1:0]   dx_q, dx_d;
  logic signed [ERR_WIDTH-1:0]   dy_q, dy_d;
  logic signed [ERR_WIDTH-1:0]   err_q, err_d;
  logic                          sx_neg_q, sx_neg_d;
  logic                          sy_neg_q, sy_neg_d;
  logic                          valid_q, valid_d;
  logic                          ready_q, ready_d;

  logic signed [ERR_WIDTH-1:0]   diff_x, diff_y, abs_x, abs_y;
  logic signed [ERR_WIDTH-1:0]   e2, err_acc;
  logic                          step_c;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    step_c   = 1'b0;
    e2       = ERR_WIDTH'(err_q <<< 1);
    err_acc  = err_q;
    diff_x   = ERR_WIDTH'(end_q.x) - ERR_WIDTH'(cur_q.x);
    diff_y   = ERR_WIDTH'(end_q.y) - ERR_WIDTH'(cur_q.y);
    abs_x    = diff_x[ERR_WIDTH-1] ? -diff_x : diff_x;
    abs_y    = diff_y[ERR_WIDTH-1] ? -diff_y : diff_y;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = '{x: x1, y: y1};
          end_d   = '{x: x2, y: y2};
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d     = abs_x;
        dy_d     = -abs_y;
        err_d    = abs_x - abs_y;
        sx_neg_d = !(cur_q.x < end_q.x);
        sy_neg_d = !(cur_q.y < end_q.y);
        state_d  = DRAW;
      end
      DRAW: begin
        // Clipped pixels advance unconditionally; visible ones wait for the writer
        step_c = !valid_q || pixel_ready;
        if (step_c) begin
          if (cur_q == end_q) begin
            state_d = IDLE;
          end else begin
            if (e2 >= dy_q) begin
              err_acc = err_acc + dy_q;
              cur_d.x = sx_neg_q ? cur_q.x - X_WIDTH'(1) : cur_q.x + X_WIDTH'(1);
            end
            if (e2 <= dx_q) begin
              err_acc = err_acc + dx_q;
              cur_d.y = sy_neg_q ? cur_q.y - Y_WIDTH'(1) : cur_q.y + Y_WIDTH'(1);
            end
            err_d = err_acc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DRAW) &&
              (cur_d.x < X_WIDTH'(HOR_ACTIVE_PIXELS)) &&
              (cur_d.y < Y_WIDTH'(VER_ACTIVE_PIXELS));
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      end_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign ready       = ready_q;
  assign pixel_valid = valid_q;
  assign pixel_x     = cur_q.x;
  assign pixel_y     = cur_q.y;

endmodule
